// File: rtl/hazard_pkg.sv
// Types and constants shared by the hazard unit and the pipeline stall controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PCWAIT = 2'd1,
        FLUSH  = 2'd2,
        HALT   = 2'd3
    } stall_state_t;

    localparam logic [15:0] NOP_INSTR    = 16'h0000;
    localparam logic [3:0]  DATA_SEG_REG = 4'hE;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Hazard events into, and per-stage pipeline controls out of, the stall controller.
interface pipe_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             data_hazard;
    logic             PC_hazard;
    logic             PC_update;
    logic             branch_taken;
    logic             hlt;
    logic             PC_stall;
    logic             IF_ID_stall;
    logic             IF_ID_flush;
    logic             ID_EX_bubble;
    logic             halted;
    logic             stall_timeout;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output data_hazard, PC_hazard, PC_update, branch_taken, hlt,
        input  PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_bubble, halted,
               stall_timeout, stall_cycles
    );

    modport slave (
        input  data_hazard, PC_hazard, PC_update, branch_taken, hlt,
        output PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_bubble, halted,
               stall_timeout, stall_cycles
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter for performance events; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end
endmodule

// File: rtl/pipe_stall_ctrl.sv
// Turns hazard, branch, PC-update and halt events into PC/IF_ID/ID_EX control,
// with a stall watchdog and a saturating stall-cycle counter.
module pipe_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int MAX_STALL    = 16,
    parameter int CNT_W        = 16
) (
    input logic               clk,
    input logic               rst,
    pipe_stall_ctrl_if.slave  bus
);
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [7:0] WD_LIMIT   = 8'(MAX_STALL - 1);

    stall_state_t     r_state;
    logic [2:0]       r_flush_cnt;
    logic [7:0]       r_stall_cnt;
    logic             r_timeout;

    logic             w_pc_stall;
    logic             w_if_id_stall;
    logic             w_if_id_flush;
    logic             w_id_ex_bubble;
    logic             w_halted;
    logic             w_wd_fire;
    logic             w_perf_inc;
    logic [CNT_W-1:0] w_stall_cycles;

    // NOTE: every output gets a default first so no path infers a latch.
    always_comb begin
        w_pc_stall     = 1'b0;
        w_if_id_stall  = 1'b0;
        w_if_id_flush  = 1'b0;
        w_id_ex_bubble = 1'b0;
        w_halted       = 1'b0;
        if (!rst) begin
            case (r_state)
                RUN: begin
                    // A taken branch squashes the stalled wrong-path instruction.
                    if (bus.branch_taken) begin
                        w_if_id_flush  = 1'b1;
                        w_id_ex_bubble = 1'b1;
                    end else if (bus.data_hazard) begin
                        w_pc_stall     = 1'b1;
                        w_if_id_stall  = 1'b1;
                        w_id_ex_bubble = 1'b1;
                    end
                end
                PCWAIT: begin
                    w_pc_stall    = 1'b1;
                    w_if_id_flush = 1'b1;
                end
                FLUSH: begin
                    w_if_id_flush  = 1'b1;
                    w_id_ex_bubble = 1'b1;
                end
                HALT: begin
                    w_pc_stall     = 1'b1;
                    w_if_id_stall  = 1'b1;
                    w_id_ex_bubble = 1'b1;
                    w_halted       = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign w_perf_inc = w_pc_stall && (r_state != HALT);
    assign w_wd_fire  = w_perf_inc && (r_stall_cnt == WD_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RUN;
            r_flush_cnt <= '0;
            r_stall_cnt <= '0;
            r_timeout   <= 1'b0;
        end else begin
            if (!w_pc_stall || w_wd_fire) begin
                r_stall_cnt <= '0;
            end else if (r_state != HALT) begin
                r_stall_cnt <= r_stall_cnt + 8'd1;
            end

            if (w_wd_fire) begin
                r_timeout <= 1'b1;
                r_state   <= RUN;
            end else begin
                case (r_state)
                    RUN: begin
                        if (bus.hlt) begin
                            r_state <= HALT;
                        end else if (bus.branch_taken) begin
                            r_state     <= FLUSH;
                            r_flush_cnt <= FLUSH_LOAD;
                        end else if (bus.PC_hazard) begin
                            r_state <= PCWAIT;
                        end
                    end
                    PCWAIT: begin
                        if (bus.branch_taken) begin
                            r_state     <= FLUSH;
                            r_flush_cnt <= FLUSH_LOAD;
                        end else if (bus.PC_update) begin
                            r_state <= RUN;
                        end
                    end
                    FLUSH: begin
                        if (bus.branch_taken) begin
                            r_flush_cnt <= FLUSH_LOAD;
                        end else if (r_flush_cnt == 3'd0) begin
                            r_state <= RUN;
                        end else begin
                            r_flush_cnt <= r_flush_cnt - 3'd1;
                        end
                    end
                    HALT:    r_state <= HALT;
                    default: r_state <= RUN;
                endcase
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cycles (
        .clk (clk),
        .rst (rst),
        .inc (w_perf_inc),
        .clr (1'b0),
        .cnt (w_stall_cycles)
    );

    assign bus.PC_stall      = w_pc_stall;
    assign bus.IF_ID_stall   = w_if_id_stall;
    assign bus.IF_ID_flush   = w_if_id_flush;
    assign bus.ID_EX_bubble  = w_id_ex_bubble;
    assign bus.halted        = w_halted;
    assign bus.stall_timeout = r_timeout;
    assign bus.stall_cycles  = w_stall_cycles;
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl; a second instance with an 8-bit counter covers saturation.
module tb_pipe_stall_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_stall_ctrl_if #(.CNT_W(16)) bus_a ();
    pipe_stall_ctrl_if #(.CNT_W(8))  bus_b ();

    pipe_stall_ctrl #(.FLUSH_CYCLES(2), .MAX_STALL(16), .CNT_W(16)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    pipe_stall_ctrl #(.FLUSH_CYCLES(2), .MAX_STALL(16), .CNT_W(8)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    // Control vector order: {PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_bubble, halted, stall_timeout}
    localparam logic [5:0] C_IDLE   = 6'b000000;
    localparam logic [5:0] C_DSTALL = 6'b110100;
    localparam logic [5:0] C_PCW    = 6'b101000;
    localparam logic [5:0] C_FLS    = 6'b001100;
    localparam logic [5:0] C_HALT   = 6'b110110;
    localparam logic [5:0] C_TO     = 6'b000001;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [5:0] ctl_a();
        return {bus_a.PC_stall, bus_a.IF_ID_stall, bus_a.IF_ID_flush,
                bus_a.ID_EX_bubble, bus_a.halted, bus_a.stall_timeout};
    endfunction

    task automatic drive(input logic dh, input logic ph, input logic pu,
                         input logic bt, input logic hl);
        bus_a.data_hazard  = dh;
        bus_a.PC_hazard    = ph;
        bus_a.PC_update    = pu;
        bus_a.branch_taken = bt;
        bus_a.hlt          = hl;
    endtask

    // Check this cycle's controls at the falling edge, then move just past the next rising edge.
    task automatic cyc(input string tag, input logic [5:0] exp);
        @(negedge clk);
        check(tag, ctl_a(), exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        bus_b.data_hazard  = 1'b0;
        bus_b.PC_hazard    = 1'b0;
        bus_b.PC_update    = 1'b0;
        bus_b.branch_taken = 1'b0;
        bus_b.hlt          = 1'b0;
        #3;
        check("reset_ctl", ctl_a(), C_IDLE);
        check("reset_cnt", bus_a.stall_cycles, 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("idle", C_IDLE);

        // Data stall for three cycles, zero latency
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc("dstall", C_DSTALL);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("dstall_end", C_IDLE);
        check("dstall_cnt", bus_a.stall_cycles, 16'd3);

        // Return: four PCWAIT cycles, PC_update in the fourth
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("ret_enter", C_IDLE);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc("ret_wait", C_PCW);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("ret_update", C_PCW);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("ret_done", C_IDLE);
        check("ret_cnt", bus_a.stall_cycles, 16'd7);

        // Branch: pulse cycle plus two FLUSH cycles
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("br_pulse", C_FLS);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("br_f1", C_FLS);
        cyc("br_f2", C_FLS);
        cyc("br_done", C_IDLE);

        // Second branch in the first FLUSH cycle reloads the count
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("br2_pulse", C_FLS);
        cyc("br2_again", C_FLS);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc("br2_ext1", C_FLS);
        cyc("br2_ext2", C_FLS);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("br2_done", C_IDLE);
        check("br_cnt", bus_a.stall_cycles, 16'd7);

        // branch_taken beats PC_update in PCWAIT
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("pcbr_enter", C_IDLE);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc("pcbr_both", C_PCW);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("pcbr_f1", C_FLS);
        cyc("pcbr_f2", C_FLS);
        cyc("pcbr_done", C_IDLE);
        check("pcbr_cnt", bus_a.stall_cycles, 16'd8);

        // branch_taken overrides a data stall in RUN
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("dhbr_pulse", C_FLS);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("dhbr_f1", C_FLS);
        cyc("dhbr_f2", C_FLS);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("dhbr_done", C_IDLE);
        check("dhbr_cnt", bus_a.stall_cycles, 16'd8);

        // Watchdog: return with no PC_update
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("wd_enter", C_IDLE);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) cyc("wd_wait", C_PCW);
        cyc("wd_fired", C_TO);
        check("wd_cnt", bus_a.stall_cycles, 16'd24);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("wd_dstall", C_DSTALL | C_TO);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("wd_sticky", C_TO);

        // hlt wins over branch_taken; HALT ignores everything
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc("hlt_enter", C_FLS | C_TO);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc("hlt_hold", C_HALT | C_TO);
        check("hlt_cnt", bus_a.stall_cycles, 16'd25);

        // Async reset out of HALT, between edges
        #2;
        rst = 1'b1;
        #1;
        check("rst_halt_ctl", ctl_a(), C_IDLE);
        check("rst_halt_cnt", bus_a.stall_cycles, 16'd0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        cyc("rst_halt_run", C_IDLE);

        // Async reset mid-PCWAIT
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("rstpc_enter", C_IDLE);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("rstpc_wait", C_PCW);
        #2;
        rst = 1'b1;
        #1;
        check("rstpc_ctl", ctl_a(), C_IDLE);
        check("rstpc_cnt", bus_a.stall_cycles, 16'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc("rstpc_run", C_IDLE);
        check("rstpc_cnt2", bus_a.stall_cycles, 16'd0);

        // Saturation on the 8-bit instance; data stall also trips its watchdog
        bus_b.data_hazard = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        check("sat_cnt", bus_b.stall_cycles, 8'hFF);
        check("sat_stall", bus_b.PC_stall, 1'b1);
        check("sat_timeout", bus_b.stall_timeout, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        check("sat_hold", bus_b.stall_cycles, 8'hFF);
        bus_b.data_hazard = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
